// File: rtl/dp_block_ram_ctl.sv
// Inferred true-dual-port RAM with byte writes, selectable read latency, write mode and clear sweep.
// Read data returns rlat (1 or 2) cycles after an enabled access; no backpressure, ports are held off only while ready is low.
module dp_block_ram_ctl #(
    parameter int abits      = 8,
    parameter int dbytes     = 4,
    parameter int blen       = 8,
    parameter int rlat       = 1,
    parameter int wmode      = 0,
    parameter int clr_on_rst = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   a_en,
    input  logic [dbytes-1:0]      a_we,
    input  logic [abits-1:0]       a_addr,
    input  logic [dbytes*blen-1:0] a_wdata,
    output logic [dbytes*blen-1:0] a_rdata,
    output logic                   a_rvalid,
    input  logic                   b_en,
    input  logic [dbytes-1:0]      b_we,
    input  logic [abits-1:0]       b_addr,
    input  logic [dbytes*blen-1:0] b_wdata,
    output logic [dbytes*blen-1:0] b_rdata,
    output logic                   b_rvalid
);
    localparam int dbits = dbytes * blen;
    localparam int depth = 2 ** abits;

    generate
        if (rlat != 1 && rlat != 2) begin : g_bad_rlat
            $fatal(1, "dp_block_ram_ctl: rlat must be 1 or 2");
        end
        if (wmode < 0 || wmode > 2) begin : g_bad_wmode
            $fatal(1, "dp_block_ram_ctl: wmode must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t             r_state;
    logic [abits-1:0]   r_cnt;
    logic               r_ready;
    logic               w_run;
    logic               w_clr;

    logic               w_en     [2];
    logic [dbytes-1:0]  w_we     [2];
    logic [abits-1:0]   w_addr   [2];
    logic [dbits-1:0]   w_wdata  [2];
    logic [dbits-1:0]   w_old    [2];
    logic [dbits-1:0]   w_merged [2];

    logic               r_rv1 [2];
    logic [dbits-1:0]   r_rd1 [2];

    logic [dbits-1:0]   r_mem [depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (clr_on_rst != 0) ? S_CLEAR : S_RUN;
            r_cnt   <= '0;
            r_ready <= (clr_on_rst == 0);
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    assign ready = r_ready;
    assign w_run = (r_state == S_RUN) && !rst;
    assign w_clr = (r_state == S_CLEAR) && !rst;

    assign w_en[0]    = a_en;
    assign w_we[0]    = a_we;
    assign w_addr[0]  = a_addr;
    assign w_wdata[0] = a_wdata;
    assign w_en[1]    = b_en;
    assign w_we[1]    = b_we;
    assign w_addr[1]  = b_addr;
    assign w_wdata[1] = b_wdata;

    // Old word plus the port's own bytes overlaid, for write_first read-back.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_old[p]    = r_mem[w_addr[p]];
            w_merged[p] = w_old[p];
            for (int i = 0; i < dbytes; i++) begin
                if (w_we[p][i]) begin
                    w_merged[p][i*blen +: blen] = w_wdata[p][i*blen +: blen];
                end
            end
        end
    end

    // Port B is applied first so port A's bytes take precedence on a shared byte.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_cnt] <= '0;
        end
        if (w_run) begin
            for (int p = 1; p >= 0; p--) begin
                for (int i = 0; i < dbytes; i++) begin
                    if (w_en[p] && w_we[p][i]) begin
                        r_mem[w_addr[p]][i*blen +: blen] <= w_wdata[p][i*blen +: blen];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_rv1[p] <= 1'b0;
                r_rd1[p] <= '0;
            end else begin
                r_rv1[p] <= w_run && w_en[p];
                if (w_run && w_en[p]) begin
                    if (!(|w_we[p])) begin
                        r_rd1[p] <= w_old[p];
                    end else if (wmode == 1) begin
                        r_rd1[p] <= w_merged[p];
                    end else if (wmode == 0) begin
                        r_rd1[p] <= w_old[p];
                    end
                end
            end
        end
    end

    generate
        if (rlat == 2) begin : g_lat2
            logic             r_rv2 [2];
            logic [dbits-1:0] r_rd2 [2];

            always_ff @(posedge clk) begin
                for (int p = 0; p < 2; p++) begin
                    if (rst) begin
                        r_rv2[p] <= 1'b0;
                        r_rd2[p] <= '0;
                    end else begin
                        r_rv2[p] <= r_rv1[p];
                        r_rd2[p] <= r_rd1[p];
                    end
                end
            end

            assign a_rvalid = r_rv2[0];
            assign a_rdata  = r_rd2[0];
            assign b_rvalid = r_rv2[1];
            assign b_rdata  = r_rd2[1];
        end else begin : g_lat1
            assign a_rvalid = r_rv1[0];
            assign a_rdata  = r_rd1[0];
            assign b_rvalid = r_rv1[1];
            assign b_rdata  = r_rd1[1];
        end
    endgenerate
endmodule

// File: tb/tb_dp_block_ram_ctl.sv
// Bench for dp_block_ram_ctl: three configurations share one stimulus stream and are checked against an array model.
module tb_dp_block_ram_ctl;
    logic        clk;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [2:0]  rdy, av, bv;
    logic [31:0] ad [3];
    logic [31:0] bd [3];

    int total = 0;
    int bad   = 0;
    bit sb_on = 0;

    // u0: rlat1 read_first clear; u1: rlat2 write_first clear; u2: rlat1 no_change, no clear
    dp_block_ram_ctl #(.abits(4), .dbytes(4), .blen(8), .rlat(1), .wmode(0), .clr_on_rst(1)) u0 (
        .clk(clk), .rst(rst), .ready(rdy[0]),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ad[0]), .a_rvalid(av[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(bd[0]), .b_rvalid(bv[0]));
    dp_block_ram_ctl #(.abits(4), .dbytes(4), .blen(8), .rlat(2), .wmode(1), .clr_on_rst(1)) u1 (
        .clk(clk), .rst(rst), .ready(rdy[1]),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ad[1]), .a_rvalid(av[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(bd[1]), .b_rvalid(bv[1]));
    dp_block_ram_ctl #(.abits(4), .dbytes(4), .blen(8), .rlat(1), .wmode(2), .clr_on_rst(0)) u2 (
        .clk(clk), .rst(rst), .ready(rdy[2]),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(ad[2]), .a_rvalid(av[2]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(bd[2]), .b_rvalid(bv[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Reference model: memory image, remaining clear cycles, and a per-port delay line of read results
    int          rl [3] = '{1, 2, 1};
    int          wm [3] = '{0, 1, 2};
    bit          cl [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] m  [3][16];
    bit          kn [3][16];
    int          left [3];
    bit          mrdy [3];
    logic [31:0] rd [3][2];
    bit          rk [3][2];
    bit          lv [3][2][2];
    logic [31:0] ld [3][2][2];
    bit          lk [3][2][2];
    bit          pe [2];
    logic [3:0]  pw [2];
    logic [3:0]  pa [2];
    logic [31:0] pd [2];
    bit          nv [2];

    always @(posedge clk) begin
        pe[0] = a_en; pw[0] = a_we; pa[0] = a_addr; pd[0] = a_wdata;
        pe[1] = b_en; pw[1] = b_we; pa[1] = b_addr; pd[1] = b_wdata;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                left[k] = cl[k] ? 16 : 0;
                mrdy[k] = !cl[k];
                if (cl[k]) for (int a = 0; a < 16; a++) begin m[k][a] = 32'h0; kn[k][a] = 1'b1; end
                for (int p = 0; p < 2; p++) begin
                    rd[k][p] = 32'h0; rk[k][p] = 1'b1;
                    for (int s = 0; s < 2; s++) begin lv[k][p][s] = 1'b0; ld[k][p][s] = 32'h0; lk[k][p][s] = 1'b1; end
                end
            end else begin
                nv[0] = 1'b0; nv[1] = 1'b0;
                if (left[k] == 0) begin
                    for (int p = 0; p < 2; p++) begin
                        if (pe[p]) begin
                            nv[p] = 1'b1;
                            if (pw[p] == 4'h0 || wm[k] == 0) begin
                                rd[k][p] = m[k][pa[p]]; rk[k][p] = kn[k][pa[p]];
                            end else if (wm[k] == 1) begin
                                rd[k][p] = mrg(m[k][pa[p]], pd[p], pw[p]);
                                rk[k][p] = kn[k][pa[p]] || (pw[p] == 4'hF);
                            end
                        end
                    end
                    for (int p = 1; p >= 0; p--) begin
                        if (pe[p] && pw[p] != 4'h0) begin
                            m[k][pa[p]] = mrg(m[k][pa[p]], pd[p], pw[p]);
                            if (pw[p] == 4'hF) kn[k][pa[p]] = 1'b1;
                        end
                    end
                end else begin
                    left[k]--;
                    if (left[k] == 0) mrdy[k] = 1'b1;
                end
                for (int p = 0; p < 2; p++) begin
                    lv[k][p][1] = lv[k][p][0]; ld[k][p][1] = ld[k][p][0]; lk[k][p][1] = lk[k][p][0];
                    lv[k][p][0] = nv[p];       ld[k][p][0] = rd[k][p];    lk[k][p][0] = rk[k][p];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sb_ready%0d", k), {31'h0, rdy[k]}, {31'h0, mrdy[k]});
                chk($sformatf("sb_a_rvalid%0d", k), {31'h0, av[k]}, {31'h0, lv[k][0][rl[k]-1]});
                chk($sformatf("sb_b_rvalid%0d", k), {31'h0, bv[k]}, {31'h0, lv[k][1][rl[k]-1]});
                if (lk[k][0][rl[k]-1]) chk($sformatf("sb_a_rdata%0d", k), ad[k], ld[k][0][rl[k]-1]);
                if (lk[k][1][rl[k]-1]) chk($sformatf("sb_b_rdata%0d", k), bd[k], ld[k][1][rl[k]-1]);
            end
        end
    end

    typedef struct {
        bit          a_en;
        logic [3:0]  a_we;
        logic [3:0]  a_addr;
        logic [31:0] a_wd;
        bit          b_en;
        logic [3:0]  b_we;
        logic [3:0]  b_addr;
        logic [31:0] b_wd;
        bit          xa_v;
        logic [31:0] xa_d;
        bit          xb_v;
        logic [31:0] xb_d;
    } vec_t;

    vec_t tv [11];

    task automatic idle();
        a_en = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    // Pulse rst for one edge, then count cycles with u0 ready low (bounded)
    task automatic pulse_count(output int n);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!rdy[0] && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n, first, last, cnt;

    initial begin
        // Expected u0 outputs (rlat 1, read_first) one cycle after each vector
        tv[0]  = '{1, 4'hF, 4'd5, 32'hAABBCCDD, 0, 4'h0, 4'd0, 32'h0,        1, 32'h0,        0, 32'h0};
        tv[1]  = '{1, 4'h3, 4'd5, 32'h11223344, 0, 4'h0, 4'd0, 32'h0,        1, 32'hAABBCCDD, 0, 32'h0};
        tv[2]  = '{0, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd5, 32'h0,        0, 32'hAABBCCDD, 1, 32'hAABB3344};
        tv[3]  = '{1, 4'hF, 4'd7, 32'h11111111, 1, 4'hC, 4'd7, 32'h22222222, 1, 32'h0,        1, 32'h0};
        tv[4]  = '{0, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd7, 32'h0,        0, 32'h0,        1, 32'h11111111};
        tv[5]  = '{1, 4'h3, 4'd7, 32'h11111111, 1, 4'hC, 4'd7, 32'h22222222, 1, 32'h11111111, 1, 32'h11111111};
        tv[6]  = '{1, 4'h0, 4'd7, 32'h0,        1, 4'h0, 4'd7, 32'h0,        1, 32'h22221111, 1, 32'h22221111};
        tv[7]  = '{1, 4'hF, 4'd9, 32'hCAFEBABE, 1, 4'h0, 4'd9, 32'h0,        1, 32'h0,        1, 32'h0};
        tv[8]  = '{0, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd9, 32'h0,        0, 32'h0,        1, 32'hCAFEBABE};
        tv[9]  = '{1, 4'h0, 4'd3, 32'h0,        0, 4'h0, 4'd0, 32'h0,        1, 32'h0,        0, 32'hCAFEBABE};
        tv[10] = '{0, 4'h0, 4'd0, 32'h0,        0, 4'h0, 4'd0, 32'h0,        0, 32'h0,        0, 32'hCAFEBABE};

        rst = 1'b1;
        idle();
        @(negedge clk);
        sb_on = 1'b1;
        @(negedge clk);

        // Clear with writes held on port A
        a_en = 1; a_we = 4'hF; a_addr = 4'd5; a_wdata = 32'hFFFFFFFF;
        pulse_count(n);
        chk("clear_len", n, 16);
        chk("clear_ready_u1", {31'h0, rdy[1]}, 32'h1);
        idle();
        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_addr = 4'(i);
            b_en = 1; b_addr = 4'(15 - i);
            @(negedge clk);
            chk($sformatf("clr_rd_a%0d", i), ad[0], 32'h0);
            chk($sformatf("clr_rd_b%0d", 15 - i), bd[0], 32'h0);
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_we = 4'hF; a_addr = 4'(i); a_wdata = 32'h0;
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            a_en = tv[i].a_en; a_we = tv[i].a_we; a_addr = tv[i].a_addr; a_wdata = tv[i].a_wd;
            b_en = tv[i].b_en; b_we = tv[i].b_we; b_addr = tv[i].b_addr; b_wdata = tv[i].b_wd;
            @(negedge clk);
            chk($sformatf("tv%0d_a_rvalid", i), {31'h0, av[0]}, {31'h0, tv[i].xa_v});
            chk($sformatf("tv%0d_a_rdata", i), ad[0], tv[i].xa_d);
            chk($sformatf("tv%0d_b_rvalid", i), {31'h0, bv[0]}, {31'h0, tv[i].xb_v});
            chk($sformatf("tv%0d_b_rdata", i), bd[0], tv[i].xb_d);
        end

        // Two-cycle latency on u1
        idle();
        a_en = 1; a_we = 4'hF; a_addr = 4'd3; a_wdata = 32'h12345678;
        @(negedge clk);
        idle();
        b_en = 1; b_addr = 4'd3;
        @(negedge clk);
        chk("lat2_early", {31'h0, bv[1]}, 32'h0);
        idle();
        @(negedge clk);
        chk("lat2_valid", {31'h0, bv[1]}, 32'h1);
        chk("lat2_data", bd[1], 32'h12345678);
        @(negedge clk);
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bv[1]) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            idle();
            if (c < 8) begin b_en = 1; b_addr = 4'(c); end
            @(negedge clk);
        end
        chk("b2b_count", cnt, 8);
        chk("b2b_span", last - first, 7);

        // Random traffic with frequent same-address collisions
        for (int c = 0; c < 1500; c++) begin
            a_en = 1'($urandom_range(0, 1));
            a_we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            a_addr = 4'($urandom); a_wdata = $urandom;
            b_en = 1'($urandom_range(0, 1));
            b_we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            b_addr = ($urandom_range(0, 2) == 0) ? a_addr : 4'($urandom);
            b_wdata = $urandom;
            @(negedge clk);
        end

        // Reset with a read in flight; u2 keeps its contents
        idle();
        a_en = 1; a_we = 4'hF; a_addr = 4'd9; a_wdata = 32'hCAFEBABE;
        @(negedge clk);
        idle();
        b_en = 1; b_addr = 4'd3;
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("inflight_u1_0", {31'h0, bv[1]}, 32'h0);
        chk("rst_ready_u0", {31'h0, rdy[0]}, 32'h0);
        chk("rst_ready_u2", {31'h0, rdy[2]}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("inflight_u1_1", {31'h0, bv[1]}, 32'h0);
        chk("noclr_ready", {31'h0, rdy[2]}, 32'h1);
        a_en = 1; a_addr = 4'd9;
        @(negedge clk);
        chk("noclr_keep_v", {31'h0, av[2]}, 32'h1);
        chk("noclr_keep_d", ad[2], 32'hCAFEBABE);
        idle();

        // Reset at clear cycle 10 restarts the full sweep
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midclr_busy", {31'h0, rdy[0]}, 32'h0);
        pulse_count(n);
        chk("midclr_len", n, 16);
        repeat (3) @(negedge clk);

        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dp_block_ram_ctl.md
Name: dp_block_ram_ctl

Overview:
- Behaviourally inferred true-dual-port block RAM for FPGA targets; no vendor primitive.
- Adds over the plain RAM wrappers:
  - selectable read latency;
  - selectable write mode;
  - per-port enables with read-valid tracking;
  - defined cross-port collision resolution;
  - optional hardware clear-on-reset state machine.
- Serves as the generic backing store for caches, register files and scratchpads in the boa SoC.

Parameters:
- abits, 8, number of address bits; depth = 2**abits words.
- dbytes, 4, bytes per word.
- blen, 8, bits per byte; dbits = dbytes*blen.
- rlat, 1, read latency in cycles; legal values are 1 and 2; anything else is a fatal elaboration error.
- wmode, 0, same-port write mode; 0 = read_first, 1 = write_first, 2 = no_change.
- clr_on_rst, 1, nonzero: zero the whole memory after reset; 0: memory contents are undefined and no clear runs.

Ports:
- clk  in  1  RAM clock.
- rst  in  1  synchronous active-high reset.
- ready  out  1  high when ports accept accesses; low while clearing.
- a_en  in  1  port A access enable.
- a_we  in  dbytes  port A per-byte write enable; qualified by a_en.
- a_addr  in  abits  port A address.
- a_wdata  in  dbits  port A write data.
- a_rdata  out  dbits  port A read data.
- a_rvalid  out  1  a_rdata is valid this cycle.
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: identical for port B.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values while rst is high and on the first cycle after it:
  - a_rdata = b_rdata = 0; a_rvalid = b_rvalid = 0;
  - ready = 0 if clr_on_rst, else 1;
  - read pipeline registers cleared.
- FSM states: CLEAR, RUN.
- rst forces CLEAR when clr_on_rst, otherwise RUN. Clear counter resets to 0.
- CLEAR:
  - Each cycle write word 0 to address cnt, then cnt = cnt+1.
  - When cnt == 2**abits-1 has been written, go to RUN.
  - Total clear time is exactly 2**abits cycles after rst deasserts; ready rises on the following cycle.
  - External en/we are ignored: writes are dropped, rvalid stays 0, rdata stays 0.
- rst asserted mid-clear restarts the clear at cnt = 0.
- rst asserted in RUN:
  - Memory contents are not modified except by the clear.
  - In-flight reads are discarded; their rvalid never asserts.
- RUN read:
  - x_en = 1 samples x_addr.
  - x_rvalid = 1 exactly rlat cycles later, with x_rdata.
  - Back-to-back reads are fully pipelined; throughput is 1 per cycle per port.
- RUN write: for each byte i with x_en & x_we[i], mem[x_addr].byte[i] = x_wdata.byte[i].
- Same-port read data on a write cycle (x_rvalid asserts regardless of mode):
  - wmode 0: old word.
  - wmode 1: merged word (new bytes where we set, old bytes elsewhere).
  - wmode 2: x_rdata holds its previous value.
- x_en = 0: x_rvalid = 0 at the matching pipeline slot; x_rdata holds its last value.
- Collision: both ports enabled, same address, same cycle.
  - Bytes written by both ports: port A data wins.
  - Bytes written by one port: that port's data.
  - A port reading (we = 0) while the other writes the same address gets the old word.
  - Both ports reading: both get the same word.
- rlat = 2: the extra stage is a plain output register. Write-mode and collision results are computed at the RAM stage and delayed unchanged.
- Addresses are exactly abits wide; there is no wrap logic beyond natural truncation.

Test Plan:
- Clear with abits=4, clr_on_rst=1: pulse rst for 1 cycle, hold a_en=1, a_we=F, a_wdata=FFFFFFFF during the clear.
  -> ready = 0 for exactly 16 cycles, then 1.
  -> reading all 16 addresses returns 00000000; the held writes had no effect.
- Latency, rlat=2: write 0x12345678 at addr 3 on port A, then read addr 3 on port B.
  -> b_rvalid asserts exactly 2 cycles after the read, with b_rdata = 12345678.
  -> back-to-back reads of addrs 0..7 give 8 consecutive valid cycles.
- Write modes, word at addr 5 = AABBCCDD, port A writes 11223344 with a_we = 0011:
  -> wmode 0: a_rdata = AABBCCDD.
  -> wmode 1: a_rdata = AABB3344.
  -> wmode 2: a_rdata = previous value.
  -> in all modes, a subsequent read of addr 5 returns AABB3344.
- Collision at addr 7: A writes 11111111 with we = 1111, B writes 22222222 with we = 1100, same cycle.
  -> memory = 11111111.
  -> repeat with A we = 0011 (same data): memory = 22221111.
- Cross-port read-during-write: addr 9 = 00000000, A writes CAFEBABE while B reads addr 9 in the same cycle.
  -> b_rdata = 00000000; next B read = CAFEBABE.
- Reset mid-operation:
  - rst at clear cycle 10 -> full 16-cycle clear restarts.
  - rst in RUN with a read in flight -> that rvalid never asserts.
  - clr_on_rst=0 -> ready = 1 on the first post-reset cycle and previously written data survives.
